// File: rtl/alu_rs_if.sv
// Dispatch, CDB, flush and issue signals of the ALU reservation station.
interface alu_rs_if;
    logic        flush;
    logic        dis_valid;
    logic        dis_ready;
    logic [4:0]  dis_opcode;
    logic [2:0]  dis_funct3;
    logic        dis_funct7;
    logic [31:0] dis_rs1_data;
    logic [31:0] dis_rs2_data;
    logic [6:0]  dis_rs1_tag;
    logic [6:0]  dis_rs2_tag;
    logic        dis_rs1_rdy;
    logic        dis_rs2_rdy;
    logic [31:0] dis_imm;
    logic [31:0] dis_pc;
    logic [2:0]  dis_rob_idx;
    logic [6:0]  dis_rd;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        alu_i_valid;
    logic [4:0]  alu_i_opcode;
    logic [2:0]  alu_i_funct3;
    logic        alu_i_funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  alu_i_rob_idx;
    logic [6:0]  alu_i_rd;

    modport master (
        output flush, dis_valid, dis_opcode, dis_funct3, dis_funct7,
               dis_rs1_data, dis_rs2_data, dis_rs1_tag, dis_rs2_tag,
               dis_rs1_rdy, dis_rs2_rdy, dis_imm, dis_pc, dis_rob_idx, dis_rd,
               cdb_valid, cdb_tag, cdb_data,
        input  dis_ready, alu_i_valid, alu_i_opcode, alu_i_funct3, alu_i_funct7,
               rs1_data, rs2_data, imm, pc, alu_i_rob_idx, alu_i_rd
    );

    modport slave (
        input  flush, dis_valid, dis_opcode, dis_funct3, dis_funct7,
               dis_rs1_data, dis_rs2_data, dis_rs1_tag, dis_rs2_tag,
               dis_rs1_rdy, dis_rs2_rdy, dis_imm, dis_pc, dis_rob_idx, dis_rd,
               cdb_valid, cdb_tag, cdb_data,
        output dis_ready, alu_i_valid, alu_i_opcode, alu_i_funct3, alu_i_funct7,
               rs1_data, rs2_data, imm, pc, alu_i_rob_idx, alu_i_rd
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers micro-ops, snoops the CDB for operands and issues the
// oldest ready op each cycle. Define ALU_RS_WAKEUP_BYPASS_EN for same-cycle wakeup issue.
module alu_rs #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    alu_rs_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] rs1_data;
        logic [6:0]  rs1_tag;
        logic        rs1_rdy;
        logic [31:0] rs2_data;
        logic [6:0]  rs2_tag;
        logic        rs2_rdy;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  rob_idx;
        logic [6:0]  rd;
    } entry_t;

    entry_t                      r_entry [DEPTH];
    logic [DEPTH-1:0]            r_valid;
    // r_age[i][j] set: entry i was dispatched before entry j.
    logic [DEPTH-1:0][DEPTH-1:0] r_age;

    logic [DEPTH-1:0] w_wake1, w_wake2, w_elig;
    logic [IW-1:0]    w_dis_idx, w_sel_idx;
    logic             w_full, w_dis_we, w_sel_any, w_issue, w_older;
    logic             w_new_hit1, w_new_hit2;
    entry_t           w_new;

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        w_full    = &r_valid;
        w_dis_we  = bus.dis_valid && !w_full && !bus.flush;
        w_dis_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!r_valid[i]) w_dis_idx = IW'(i);
    end

    always_comb begin
        w_new_hit1     = bus.cdb_valid && !bus.dis_rs1_rdy && (bus.cdb_tag == bus.dis_rs1_tag);
        w_new_hit2     = bus.cdb_valid && !bus.dis_rs2_rdy && (bus.cdb_tag == bus.dis_rs2_tag);
        w_new.opcode   = bus.dis_opcode;
        w_new.funct3   = bus.dis_funct3;
        w_new.funct7   = bus.dis_funct7;
        w_new.rs1_data = w_new_hit1 ? bus.cdb_data : bus.dis_rs1_data;
        w_new.rs1_tag  = bus.dis_rs1_tag;
        w_new.rs1_rdy  = bus.dis_rs1_rdy || w_new_hit1;
        w_new.rs2_data = w_new_hit2 ? bus.cdb_data : bus.dis_rs2_data;
        w_new.rs2_tag  = bus.dis_rs2_tag;
        w_new.rs2_rdy  = bus.dis_rs2_rdy || w_new_hit2;
        w_new.imm      = bus.dis_imm;
        w_new.pc       = bus.dis_pc;
        w_new.rob_idx  = bus.dis_rob_idx;
        w_new.rd       = bus.dis_rd;
    end

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        w_elig  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i] = bus.cdb_valid && !r_entry[i].rs1_rdy && (r_entry[i].rs1_tag == bus.cdb_tag);
            w_wake2[i] = bus.cdb_valid && !r_entry[i].rs2_rdy && (r_entry[i].rs2_tag == bus.cdb_tag);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            w_elig[i]  = r_valid[i] && (r_entry[i].rs1_rdy || w_wake1[i])
                                    && (r_entry[i].rs2_rdy || w_wake2[i]);
`else
            w_elig[i]  = r_valid[i] && r_entry[i].rs1_rdy && r_entry[i].rs2_rdy;
`endif
        end
    end

    // Oldest eligible entry: one that is older than every other eligible entry.
    always_comb begin
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        w_older   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_older = w_elig[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && w_elig[j] && !r_age[i][j]) w_older = 1'b0;
            if (w_older) begin
                w_sel_any = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
        w_issue = w_sel_any && !bus.flush;
    end

    always_comb begin
        bus.dis_ready     = !w_full;
        bus.alu_i_valid   = w_issue;
        bus.alu_i_opcode  = '0;
        bus.alu_i_funct3  = '0;
        bus.alu_i_funct7  = 1'b0;
        bus.rs1_data      = '0;
        bus.rs2_data      = '0;
        bus.imm           = '0;
        bus.pc            = '0;
        bus.alu_i_rob_idx = '0;
        bus.alu_i_rd      = '0;
        if (w_issue) begin
            bus.alu_i_opcode  = r_entry[w_sel_idx].opcode;
            bus.alu_i_funct3  = r_entry[w_sel_idx].funct3;
            bus.alu_i_funct7  = r_entry[w_sel_idx].funct7;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            bus.rs1_data      = r_entry[w_sel_idx].rs1_rdy ? r_entry[w_sel_idx].rs1_data : bus.cdb_data;
            bus.rs2_data      = r_entry[w_sel_idx].rs2_rdy ? r_entry[w_sel_idx].rs2_data : bus.cdb_data;
`else
            bus.rs1_data      = r_entry[w_sel_idx].rs1_data;
            bus.rs2_data      = r_entry[w_sel_idx].rs2_data;
`endif
            bus.imm           = r_entry[w_sel_idx].imm;
            bus.pc            = r_entry[w_sel_idx].pc;
            bus.alu_i_rob_idx = r_entry[w_sel_idx].rob_idx;
            bus.alu_i_rd      = r_entry[w_sel_idx].rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_age   <= '0;
        end else if (bus.flush) begin
            r_valid <= '0;
        end else begin
            if (w_issue) r_valid[w_sel_idx] <= 1'b0;
            if (w_dis_we) begin
                r_valid[w_dis_idx] <= 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    r_age[j][w_dis_idx] <= (IW'(j) != w_dis_idx);
                    r_age[w_dis_idx][j] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the payload array is not reset; it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_dis_we && w_dis_idx == IW'(i)) begin
                r_entry[i] <= w_new;
            end else begin
                if (w_wake1[i]) begin
                    r_entry[i].rs1_data <= bus.cdb_data;
                    r_entry[i].rs1_rdy  <= 1'b1;
                end
                if (w_wake2[i]) begin
                    r_entry[i].rs2_data <= bus.cdb_data;
                    r_entry[i].rs2_rdy  <= 1'b1;
                end
            end
        end
    end
endmodule
